// File: rtl/inv_sub_shift_unit.sv
// Iterative InvShiftRows + InvSubBytes stage for the AES-128 decryption datapath.
// Processes LANES bytes per cycle through combinational inverse S-boxes.

module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254 = prod x^(2^i), i = 1..7; maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    logic [7:0] aff;

    // Inverse affine transform precedes the field inversion
    always_comb begin
        aff    = 8'h00;
        aff[0] = in_byte[2] ^ in_byte[5] ^ in_byte[7] ^ 1'b1;
        aff[1] = in_byte[3] ^ in_byte[6] ^ in_byte[0];
        aff[2] = in_byte[4] ^ in_byte[7] ^ in_byte[1] ^ 1'b1;
        aff[3] = in_byte[5] ^ in_byte[0] ^ in_byte[2];
        aff[4] = in_byte[6] ^ in_byte[1] ^ in_byte[3];
        aff[5] = in_byte[7] ^ in_byte[2] ^ in_byte[4];
        aff[6] = in_byte[0] ^ in_byte[3] ^ in_byte[5];
        aff[7] = in_byte[1] ^ in_byte[4] ^ in_byte[6];
    end

    assign out_byte = ginv(aff);

endmodule

module inv_sub_shift_unit #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0][7:0] st_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [3:0] lane_idx [LANES];
    logic [7:0] sub_in   [LANES];
    logic [7:0] sub_out  [LANES];

    // Byte i of the state lives at st_q[15-i] so out_data matches the port byte order
    function automatic logic [15:0][7:0] inv_shift_rows(input logic [127:0] d);
        logic [15:0][7:0] s;
        logic [15:0][7:0] o;
        s = d;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(15 - (4 * c + r))] = s[4'(15 - (4 * ((c - r + 4) % 4) + r))];
            end
        end
        return o;
    endfunction

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = 4'((32'(cnt_q) * LANES) + 32'(k));
            sub_in[k]   = st_q[4'd15 - lane_idx[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        inv_sbox u_inv_sbox (
            .in_byte  (sub_in[k]),
            .out_byte (sub_out[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q       <= inv_shift_rows(in_data);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES; k++) begin
                        st_q[4'd15 - lane_idx[k]] <= sub_out[k];
                    end
                    if (cnt_q == CW'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_inv_sub_shift_unit.sv
// Directed bench for inv_sub_shift_unit: one instance per legal LANES value,
// instance 2 (LANES=4) carries the detailed handshake tests.

module tb_inv_sub_shift_unit;

    localparam logic [127:0] V_ORDER  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R_ORDER  = 128'h52f3a338_3009d79e_bf366afb_8140a5d5;
    localparam logic [127:0] V_63     = {16{8'h63}};
    localparam logic [127:0] R_ZERO   = {16{8'h52}};
    localparam int           M        = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic         in_ready_w  [5];
    logic         out_valid_w [5];
    logic [127:0] out_data_w  [5];

    int checks;
    int errors;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_shift_unit #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_data   (in_data),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        while (!in_ready_w[M] && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 128'(in_ready_w[M]), 128'(1));
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_w[M] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int lats [5];
        int hits [3];
        int nh;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #22;
        chk("reset_in_ready", 128'(in_ready_w[M]), 128'(1));
        chk("reset_out_valid", 128'(out_valid_w[M]), 128'(0));
        chk("reset_out_data", out_data_w[M], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero state
        send(128'h0);
        wait_valid(lat);
        chk("zero_latency", 128'(lat), 128'(4));
        chk("zero_data", out_data_w[M], R_ZERO);
        release_out();
        chk("zero_in_ready_after", 128'(in_ready_w[M]), 128'(1));
        chk("zero_out_valid_after", 128'(out_valid_w[M]), 128'(0));

        // Byte ordering through InvShiftRows
        send(V_ORDER);
        wait_valid(lat);
        chk("order_latency", 128'(lat), 128'(4));
        chk("order_data", out_data_w[M], R_ORDER);
        release_out();

        // 0x63 is the S-box image of 0; also exercise backpressure
        send(V_63);
        wait_valid(lat);
        chk("fixed_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            chk("bp_data", out_data_w[M], 128'h0);
            chk("bp_out_valid", 128'(out_valid_w[M]), 128'(1));
            chk("bp_in_ready", 128'(in_ready_w[M]), 128'(0));
            tick();
        end
        release_out();
        chk("bp_in_ready_after", 128'(in_ready_w[M]), 128'(1));

        // Asynchronous reset mid-BUSY at cnt=2
        send(128'h0);
        tick();
        tick();
        chk("midbusy_in_ready", 128'(in_ready_w[M]), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 128'(in_ready_w[M]), 128'(1));
        chk("async_out_valid", 128'(out_valid_w[M]), 128'(0));
        chk("async_out_data", out_data_w[M], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_reset_no_valid", 128'(out_valid_w[M]), 128'(0));
        end
        send(128'h0);
        wait_valid(lat);
        chk("post_reset_latency", 128'(lat), 128'(4));
        chk("post_reset_data", out_data_w[M], R_ZERO);
        release_out();

        // LANES sweep: reset all instances, accept together, compare latency and data
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(V_ORDER);
        for (int g = 0; g < 5; g++) lats[g] = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            for (int g = 0; g < 5; g++) begin
                if (out_valid_w[g] && lats[g] < 0) lats[g] = t;
            end
        end
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("sweep_latency_lanes%0d", 1 << g), 128'(lats[g]), 128'(16 >> g));
            chk($sformatf("sweep_data_lanes%0d", 1 << g), out_data_w[g], R_ORDER);
        end
        release_out();

        // Back-to-back with out_ready tied high: one result every N+2 cycles
        in_data   = 128'h0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nh = 0;
        for (int t = 0; t < 40 && nh < 3; t++) begin
            tick();
            if (out_valid_w[M]) begin
                chk("b2b_data", out_data_w[M], R_ZERO);
                hits[nh] = t;
                nh++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(nh), 128'(3));
        if (nh == 3) begin
            chk("b2b_interval0", 128'(hits[1] - hits[0]), 128'(6));
            chk("b2b_interval1", 128'(hits[2] - hits[1]), 128'(6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
